// File: rtl/aquila_pkg.sv
// rtl/aquila_pkg.sv - shared ALU, writeback-select and branch-condition encodings
package aquila_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] MTR_ALU  = 2'd0;
    localparam logic [1:0] MTR_LOAD = 2'd1;
    localparam logic [1:0] MTR_PC4  = 2'd2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_stage_alu.sv
// rtl/ex_stage_alu.sv - combinational integer ALU (op, a, b) -> result
//
// Ports:
//   op     : ALU operation code (aquila_pkg ALU_*); unused codes give 0
//   a, b   : operands; shift amount is b[4:0]
//   result : operation result
module alu
    import aquila_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = 32'd0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {31'd0, a < b};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $signed(a) >>> shamt;
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = 32'd0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, branch/jump resolution, EX/MEM register
//
// Optional feature macro: AQUILA_EX_FWD_EN (operand forwarding from MEM/WB).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall, flush        : EX/MEM hold / bubble injection (flush wins)
//   ex_*                : decoded instruction from the ID/EX register
//   fwd_mem_*, fwd_wb_* : MEM/WB producers (used only with forwarding enabled)
//   redirect_valid/pc   : combinational fetch redirect for taken branches/jumps
//   mem_*               : EX/MEM register outputs
module ex_stage
    import aquila_pkg::*;
#(
    parameter int          XLEN          = 32,
    parameter logic [31:0] RESET_PC_MASK = 32'hFFFF_FFFE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1_val,
    input  logic [XLEN-1:0] ex_rs2_val,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [4:0]      ex_rd,
    input  logic            ex_opa_sel,
    input  logic            ex_opb_sel,
    input  logic [3:0]      ex_alu_op,
    input  logic [2:0]      ex_br_funct3,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic            ex_is_load,
    input  logic            ex_is_store,
    input  logic            ex_reg_write,
    input  logic [1:0]      ex_mem_to_reg,
    input  logic [4:0]      ex_rs1_addr,
    input  logic [4:0]      ex_rs2_addr,
    input  logic [4:0]      fwd_mem_rd,
    input  logic            fwd_mem_reg_write,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic [4:0]      fwd_wb_rd,
    input  logic            fwd_wb_reg_write,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_pc,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [XLEN-1:0] mem_pc_plus4,
    output logic [4:0]      mem_rd,
    output logic            mem_is_load,
    output logic            mem_is_store,
    output logic            mem_reg_write,
    output logic [1:0]      mem_mem_to_reg,
    output logic            mem_exc_misalign
);

    logic [XLEN-1:0] rs1, rs2;

`ifdef AQUILA_EX_FWD_EN
    // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
    always_comb begin
        rs1 = ex_rs1_val;
        if (fwd_mem_reg_write && fwd_mem_rd == ex_rs1_addr && fwd_mem_rd != 5'd0)
            rs1 = fwd_mem_data;
        else if (fwd_wb_reg_write && fwd_wb_rd == ex_rs1_addr && fwd_wb_rd != 5'd0)
            rs1 = fwd_wb_data;
    end

    always_comb begin
        rs2 = ex_rs2_val;
        if (fwd_mem_reg_write && fwd_mem_rd == ex_rs2_addr && fwd_mem_rd != 5'd0)
            rs2 = fwd_mem_data;
        else if (fwd_wb_reg_write && fwd_wb_rd == ex_rs2_addr && fwd_wb_rd != 5'd0)
            rs2 = fwd_wb_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_rs1_addr, ex_rs2_addr, fwd_mem_rd, fwd_mem_reg_write,
                          fwd_mem_data, fwd_wb_rd, fwd_wb_reg_write, fwd_wb_data};
    assign rs1 = ex_rs1_val;
    assign rs2 = ex_rs2_val;
`endif

    logic [XLEN-1:0] op_a, op_b, alu_result;
    assign op_a = ex_opa_sel ? ex_pc  : rs1;
    assign op_b = ex_opb_sel ? ex_imm : rs2;

    alu u_alu (
        .op     (ex_alu_op),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result)
    );

    // Branch condition always compares the register operands, not op_a/op_b.
    logic br_taken;
    always_comb begin
        br_taken = 1'b0;
        case (ex_br_funct3)
            F3_BEQ:  br_taken = (rs1 == rs2);
            F3_BNE:  br_taken = (rs1 != rs2);
            F3_BLT:  br_taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  br_taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: br_taken = (rs1 <  rs2);
            F3_BGEU: br_taken = (rs1 >= rs2);
            default: br_taken = 1'b0;
        endcase
    end

    logic take;
    assign take = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & br_taken));

    assign redirect_pc    = ex_is_jalr ? ((rs1 + ex_imm) & RESET_PC_MASK) : (ex_pc + ex_imm);
    // Gating with stall keeps a held instruction from redirecting on every stalled cycle.
    assign redirect_valid = take & ~stall;

    logic misalign;
    assign misalign = take & (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid        <= 1'b0;
            mem_pc           <= '0;
            mem_alu_result   <= '0;
            mem_store_data   <= '0;
            mem_pc_plus4     <= '0;
            mem_rd           <= 5'd0;
            mem_is_load      <= 1'b0;
            mem_is_store     <= 1'b0;
            mem_reg_write    <= 1'b0;
            mem_mem_to_reg   <= 2'd0;
            mem_exc_misalign <= 1'b0;
        end else if (flush) begin
            mem_valid        <= 1'b0;
            mem_is_load      <= 1'b0;
            mem_is_store     <= 1'b0;
            mem_reg_write    <= 1'b0;
            mem_mem_to_reg   <= 2'd0;
            mem_exc_misalign <= 1'b0;
        end else if (!stall) begin
            mem_valid        <= ex_valid;
            mem_pc           <= ex_pc;
            mem_alu_result   <= alu_result;
            mem_store_data   <= rs2;
            mem_pc_plus4     <= ex_pc + 32'd4;
            mem_rd           <= ex_rd;
            mem_is_load      <= ex_valid & ex_is_load;
            mem_is_store     <= ex_valid & ex_is_store;
            // A misaligned jump target raises an exception instead of writing back.
            mem_reg_write    <= ex_valid & ex_reg_write & ~misalign;
            mem_mem_to_reg   <= {2{ex_valid}} & ex_mem_to_reg;
            mem_exc_misalign <= misalign;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized model-checked bench for ex_stage
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_opa_sel, ex_opb_sel;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_br_funct3;
    logic        ex_is_branch, ex_is_jal, ex_is_jalr, ex_is_load, ex_is_store;
    logic        ex_reg_write;
    logic [1:0]  ex_mem_to_reg;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic        fwd_mem_reg_write, fwd_wb_reg_write;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_valid;
    logic [31:0] mem_pc, mem_alu_result, mem_store_data, mem_pc_plus4;
    logic [4:0]  mem_rd;
    logic        mem_is_load, mem_is_store, mem_reg_write;
    logic [1:0]  mem_mem_to_reg;
    logic        mem_exc_misalign;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_opa_sel(ex_opa_sel), .ex_opb_sel(ex_opb_sel), .ex_alu_op(ex_alu_op),
        .ex_br_funct3(ex_br_funct3), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_rs1_addr(ex_rs1_addr),
        .ex_rs2_addr(ex_rs2_addr), .fwd_mem_rd(fwd_mem_rd),
        .fwd_mem_reg_write(fwd_mem_reg_write), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_rd(fwd_wb_rd), .fwd_wb_reg_write(fwd_wb_reg_write),
        .fwd_wb_data(fwd_wb_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd), .mem_is_load(mem_is_load),
        .mem_is_store(mem_is_store), .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_exc_misalign(mem_exc_misalign)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc, alu, sd, pc4;
        logic [4:0]  rd;
        logic        ld, st, rw;
        logic [1:0]  mtr;
        logic        mis;
    } exmem_t;

    exmem_t      model, model_next;
    logic        exp_redir;
    logic [31:0] exp_target;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] addr, input logic [31:0] val);
`ifdef AQUILA_EX_FWD_EN
        if (fwd_mem_reg_write && addr == fwd_mem_rd && addr != 0) return fwd_mem_data;
        if (fwd_wb_reg_write && addr == fwd_wb_rd && addr != 0) return fwd_wb_data;
`endif
        return val;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        longint sa, sb;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return 32'(sa >>> sh);
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic cond_ref(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Settle inputs, check redirect against the model, and prepare the next EX/MEM state.
    task automatic comb_check();
        logic [31:0] r1, r2, a, b;
        logic        jump;
        #1;
        r1 = operand(ex_rs1_addr, ex_rs1_val);
        r2 = operand(ex_rs2_addr, ex_rs2_val);
        a  = ex_opa_sel ? ex_pc : r1;
        b  = ex_opb_sel ? ex_imm : r2;
        exp_target = ex_is_jalr ? ((r1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
        jump = ex_valid && (ex_is_jal || ex_is_jalr || (ex_is_branch && cond_ref(ex_br_funct3, r1, r2)));
        exp_redir = jump && !stall;
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_redir});
        if (exp_redir) chk("redirect_pc", redirect_pc, exp_target);

        model_next = model;
        if (rst) begin
            model_next = '{1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        end else if (flush) begin
            model_next.valid = 0; model_next.ld = 0; model_next.st = 0;
            model_next.rw = 0; model_next.mtr = 0; model_next.mis = 0;
        end else if (!stall) begin
            model_next.valid = ex_valid;
            model_next.pc    = ex_pc;
            model_next.alu   = alu_ref(ex_alu_op, a, b);
            model_next.sd    = r2;
            model_next.pc4   = ex_pc + 4;
            model_next.rd    = ex_rd;
            model_next.ld    = ex_valid && ex_is_load;
            model_next.st    = ex_valid && ex_is_store;
            model_next.mis   = jump && (exp_target % 4 != 0);
            model_next.rw    = ex_valid && ex_reg_write && !model_next.mis;
            model_next.mtr   = ex_valid ? ex_mem_to_reg : 2'd0;
        end
    endtask

    task automatic clock_check();
        @(posedge clk);
        #1;
        model = model_next;
        chk("mem_valid",        {31'd0, mem_valid},        {31'd0, model.valid});
        chk("mem_pc",           mem_pc,                    model.pc);
        chk("mem_alu_result",   mem_alu_result,            model.alu);
        chk("mem_store_data",   mem_store_data,            model.sd);
        chk("mem_pc_plus4",     mem_pc_plus4,              model.pc4);
        chk("mem_rd",           {27'd0, mem_rd},           {27'd0, model.rd});
        chk("mem_is_load",      {31'd0, mem_is_load},      {31'd0, model.ld});
        chk("mem_is_store",     {31'd0, mem_is_store},     {31'd0, model.st});
        chk("mem_reg_write",    {31'd0, mem_reg_write},    {31'd0, model.rw});
        chk("mem_mem_to_reg",   {30'd0, mem_mem_to_reg},   {30'd0, model.mtr});
        chk("mem_exc_misalign", {31'd0, mem_exc_misalign}, {31'd0, model.mis});
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0;
        ex_valid = 0; ex_pc = 0; ex_rs1_val = 0; ex_rs2_val = 0; ex_imm = 0; ex_rd = 0;
        ex_opa_sel = 0; ex_opb_sel = 0; ex_alu_op = 0; ex_br_funct3 = 0;
        ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_is_load = 0; ex_is_store = 0;
        ex_reg_write = 0; ex_mem_to_reg = 0; ex_rs1_addr = 0; ex_rs2_addr = 0;
        fwd_mem_rd = 0; fwd_mem_reg_write = 0; fwd_mem_data = 0;
        fwd_wb_rd = 0; fwd_wb_reg_write = 0; fwd_wb_data = 0;
    endtask

    task automatic step();
        comb_check();
        clock_check();
    endtask

    task automatic randomize_inputs();
        rst   = ($urandom_range(0, 99) < 3);
        stall = ($urandom_range(0, 99) < 25);
        flush = ($urandom_range(0, 99) < 10);
        ex_valid = ($urandom_range(0, 99) < 80);
        ex_pc = {$urandom_range(0, 16'hFFFF), 2'b00} + ($urandom_range(0, 9) == 0 ? 32'd2 : 32'd0);
        ex_rs1_val = $urandom;
        ex_rs2_val = ($urandom_range(0, 3) == 0) ? ex_rs1_val : $urandom;
        ex_imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(12'($urandom)));
        ex_rd = 5'($urandom);
        ex_opa_sel = 1'($urandom); ex_opb_sel = 1'($urandom);
        ex_alu_op = 4'($urandom); ex_br_funct3 = 3'($urandom);
        case ($urandom_range(0, 4))
            0: begin ex_is_branch = 1; ex_is_jal = 0; ex_is_jalr = 0; end
            1: begin ex_is_branch = 0; ex_is_jal = 1; ex_is_jalr = 0; end
            2: begin ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 1; end
            default: begin ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; end
        endcase
        ex_is_load = 1'($urandom); ex_is_store = 1'($urandom);
        ex_reg_write = 1'($urandom); ex_mem_to_reg = 2'($urandom);
        ex_rs1_addr = 5'($urandom_range(0, 7)); ex_rs2_addr = 5'($urandom_range(0, 7));
        fwd_mem_rd = 5'($urandom_range(0, 7)); fwd_mem_reg_write = 1'($urandom);
        fwd_mem_data = $urandom;
        fwd_wb_rd = 5'($urandom_range(0, 7)); fwd_wb_reg_write = 1'($urandom);
        fwd_wb_data = $urandom;
    endtask

    exmem_t snap;

    initial begin
        model = '{1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        idle();
        rst = 1;
        @(posedge clk); #1;
        step();
        chk("reset mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("reset mem_alu_result", mem_alu_result, 32'd0);
        rst = 0;

        // ADD rs1 + imm
        ex_valid = 1; ex_rs1_val = 5; ex_imm = 32'hFFFF_FFFD; ex_opb_sel = 1;
        ex_alu_op = 0; ex_reg_write = 1; ex_rd = 3;
        comb_check();
        chk("add no redirect", {31'd0, redirect_valid}, 32'd0);
        clock_check();
        chk("add result", mem_alu_result, 32'd2);
        chk("add reg_write", {31'd0, mem_reg_write}, 32'd1);

        // BEQ taken, then BNE not taken
        idle();
        ex_valid = 1; ex_pc = 32'h100; ex_rs1_val = 7; ex_rs2_val = 7; ex_imm = 32'h20;
        ex_is_branch = 1; ex_br_funct3 = 3'b000;
        comb_check();
        chk("beq redirect", {31'd0, redirect_valid}, 32'd1);
        chk("beq target", redirect_pc, 32'h120);
        clock_check();
        ex_br_funct3 = 3'b001;
        comb_check();
        chk("bne no redirect", {31'd0, redirect_valid}, 32'd0);
        clock_check();

        // JALR to odd address: masked target 0x202 is still misaligned
        idle();
        ex_valid = 1; ex_rs1_val = 32'h203; ex_imm = 0; ex_is_jalr = 1; ex_reg_write = 1;
        ex_mem_to_reg = 2;
        comb_check();
        chk("jalr target", redirect_pc, 32'h202);
        clock_check();
        chk("jalr misalign", {31'd0, mem_exc_misalign}, 32'd1);
        chk("jalr reg_write", {31'd0, mem_reg_write}, 32'd0);

        // JAL held by a 3-cycle stall fires exactly once on release
        idle();
        ex_valid = 1; ex_pc = 32'h400; ex_imm = 32'h40; ex_is_jal = 1; stall = 1;
        snap = model;
        for (int i = 0; i < 3; i++) begin
            comb_check();
            chk("stall no redirect", {31'd0, redirect_valid}, 32'd0);
            clock_check();
            chk("stall hold pc", mem_pc, snap.pc);
        end
        stall = 0;
        comb_check();
        chk("release redirect", {31'd0, redirect_valid}, 32'd1);
        chk("release target", redirect_pc, 32'h440);
        clock_check();
        idle();
        comb_check();
        chk("no second redirect", {31'd0, redirect_valid}, 32'd0);
        clock_check();

        // flush beats stall
        ex_valid = 1; ex_reg_write = 1; step();
        flush = 1; stall = 1;
        step();
        chk("flush+stall valid", {31'd0, mem_valid}, 32'd0);

        // reset while valid clears everything
        idle();
        ex_valid = 1; ex_pc = 32'h88; ex_rs2_val = 32'h55; ex_is_load = 1; ex_reg_write = 1;
        step();
        rst = 1;
        step();
        chk("rst valid", {31'd0, mem_valid}, 32'd0);
        chk("rst pc", mem_pc, 32'd0);
        chk("rst store_data", mem_store_data, 32'd0);

        // forwarding priority and x0
        idle();
        ex_valid = 1; ex_opb_sel = 1; ex_imm = 0; ex_alu_op = 0;
        ex_rs1_addr = 5; ex_rs1_val = 32'h11;
        fwd_mem_rd = 5; fwd_mem_reg_write = 1; fwd_mem_data = 32'hAA;
        fwd_wb_rd = 5; fwd_wb_reg_write = 1; fwd_wb_data = 32'hBB;
        step();
`ifdef AQUILA_EX_FWD_EN
        chk("fwd mem priority", mem_alu_result, 32'hAA);
`else
        chk("fwd ignored", mem_alu_result, 32'h11);
`endif
        ex_rs1_addr = 0; fwd_mem_rd = 0; fwd_wb_rd = 0;
        step();
        chk("x0 not forwarded", mem_alu_result, 32'h11);

        // randomized run
        for (int n = 0; n < 2000; n++) begin
            randomize_inputs();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX pipeline-register outputs.
- Computes ALU results and resolves branches and jumps. Produces a PC redirect and a flush request toward fetch, decode and the ID/EX register.
- Registers its results into the EX/MEM boundary, which feeds the memory stage.

Parameters:
XLEN, 32, datapath width (only 32 supported)
RESET_PC_MASK, 32'hFFFF_FFFE, mask applied to JALR target (clears bit 0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold EX/MEM register (memory-stage back-pressure)
flush  in  1  inject bubble into EX/MEM
ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  in  1/32/32/32/32  from ID/EX
ex_rd  in  5  destination register
ex_opa_sel  in  1  0=rs1, 1=pc
ex_opb_sel  in  1  0=rs2, 1=imm
ex_alu_op  in  4  ALU operation code (package)
ex_br_funct3  in  3  branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU)
ex_is_branch, ex_is_jal, ex_is_jalr, ex_is_load, ex_is_store  in  1 each  instruction class
ex_reg_write  in  1  writeback enable
ex_mem_to_reg  in  2  0=ALU, 1=load, 2=pc+4
ex_rs1_addr, ex_rs2_addr  in  5 each  source indices (forwarding only)
fwd_mem_rd, fwd_mem_reg_write, fwd_mem_data  in  5/1/32  MEM-stage producer
fwd_wb_rd, fwd_wb_reg_write, fwd_wb_data  in  5/1/32  WB-stage producer
redirect_valid  out  1  combinational; take redirect_pc, flush younger stages
redirect_pc  out  32  target address
mem_valid, mem_pc, mem_alu_result, mem_store_data, mem_pc_plus4  out  1/32/32/32/32  EX/MEM register
mem_rd, mem_is_load, mem_is_store, mem_reg_write, mem_mem_to_reg  out  5/1/1/1/2
mem_exc_misalign  out  1  taken target not word-aligned

Behaviour:
- ALU codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB. Codes 11-15 give 0.
- Shift amount = opB[4:0]. SLT/SLTU produce 32'd0 or 32'd1.
- Branch compare always uses rs1 vs rs2 (post-forwarding), independent of opa/opb select. Undefined funct3 (010, 011) = not taken.
- Targets:
  - branch/JAL: pc+imm.
  - JALR: (rs1+imm) & RESET_PC_MASK.
  - All sums mod 2^32.
- Static not-taken prediction.
- redirect_valid = ex_valid & !stall & (jal | jalr | (branch & taken)).
- redirect_valid is held low while stalled, so a stalled EX never redirects twice.
- EX/MEM register:
  - rst → every mem_* output 0.
  - else flush → mem_valid, mem_is_load, mem_is_store, mem_reg_write, mem_exc_misalign, mem_mem_to_reg = 0; data fields hold.
  - else !stall → capture. Each control output is ANDed with ex_valid.
  - else hold.
- flush has priority over stall; rst has priority over all.
- Latency: ex_* inputs to mem_* outputs = 1 cycle. Redirect = 0 cycles.
- mem_exc_misalign = redirect condition & (redirect_pc[1:0] != 0). When set, mem_reg_write is forced to 0. Redirect still fires.
- mem_store_data = rs2 (post-forwarding). mem_pc_plus4 = ex_pc + 4.
- Reset mid-stall: the register clears next edge; redirect_valid is 0 while the invalid bubble sits in EX.

Optional Feature:
- Macro AQUILA_EX_FWD_EN.
- Defined: operands are forwarded. For each of rs1/rs2:
  - Use fwd_mem_data if fwd_mem_reg_write & rd==addr & rd!=0.
  - Else use fwd_wb_data under the same rule for the WB producer.
  - Else use ex_rs*_val. MEM has priority over WB.
- Undefined: ex_rs*_val are used directly. The fwd_* and ex_rs*_addr ports are present but ignored.

Decomposition:
- Package aquila_pkg: ALU op localparams, mem_to_reg codes (MTR_ALU/MTR_LOAD/MTR_PC4), branch funct3 constants.
- Sub-module alu: purely combinational, (op, a, b) → result.

Test Plan:
- ADD with opb=imm: rs1=5, imm=-3 → next cycle mem_alu_result=2, mem_reg_write=1. redirect_valid=0.
- BEQ taken: pc=0x100, rs1=rs2=7, imm=0x20 → same cycle redirect_valid=1, redirect_pc=0x120. BNE with the same operands → no redirect.
- JALR: rs1=0x203, imm=0 → redirect_pc=0x202, mem_exc_misalign=1, mem_reg_write=0.
- Stall held 3 cycles during a taken JAL → redirect_valid=0 throughout the stall, mem_* outputs held. Fires once on release.
- flush and stall asserted together → mem_valid=0 next cycle. Assert rst while valid → all mem_* outputs 0 next edge.
- AQUILA_EX_FWD_EN: MEM and WB both write x5 (0xAA, 0xBB), ex_rs1_addr=5 → operand 0xAA. Write to x0 is never forwarded.
